// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Optional performance counters are enabled with STALL_PERF_CNT_EN.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } stall_state_t;

  // Data-memory operation encodings, mirrored from defines.sv
  localparam logic [1:0] MEM_OP_LD  = 2'd0;
  localparam logic [1:0] MEM_OP_LDM = 2'd1;
  localparam logic [1:0] MEM_OP_ST  = 2'd2;
  localparam logic [1:0] MEM_OP_STM = 2'd3;

  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_perf_counter.sv
// Saturating event counter used for the stall/flush performance statistics.
module stall_perf_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges mem waits, branch squash and load-use stalls.
// Define STALL_PERF_CNT_EN to build the stall_cycles / flush_count counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_write_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned      WCW         = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [WCW-1:0]   TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

  stall_state_t   state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           freeze;
  logic           pc_c, if_id_we_c, if_id_flush_c, id_ex_we_c, id_ex_bubble_c;
  logic           ex_mem_we_c, mem_wb_bubble_c;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ack) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == TIMEOUT_VAL) state_d    = ERROR;
          else                           wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERROR:   freeze = 1'b1;
      default: begin
        freeze  = 1'b1;
        state_d = RUN;
      end
    endcase
  end

  // Freeze (mem wait or ERROR) outranks branch, which outranks load-use.
  always_comb begin
    pc_c            = 1'b1;
    if_id_we_c      = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_we_c      = 1'b1;
    id_ex_bubble_c  = 1'b0;
    ex_mem_we_c     = 1'b1;
    mem_wb_bubble_c = 1'b0;
    if (freeze) begin
      pc_c            = 1'b0;
      if_id_we_c      = 1'b0;
      id_ex_we_c      = 1'b0;
      ex_mem_we_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
    end else if (branch_taken) begin
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end else if (load_use_stall) begin
      pc_c           = 1'b0;
      if_id_we_c     = 1'b0;
      id_ex_bubble_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Mealy outputs are forced low for the whole reset assertion.
  assign pc_write_en     = rst_n & pc_c;
  assign if_id_write_en  = rst_n & if_id_we_c;
  assign if_id_flush     = rst_n & if_id_flush_c;
  assign id_ex_write_en  = rst_n & id_ex_we_c;
  assign id_ex_bubble    = rst_n & id_ex_bubble_c;
  assign ex_mem_write_en = rst_n & ex_mem_we_c;
  assign mem_wb_bubble   = rst_n & mem_wb_bubble_c;
  assign mem_timeout     = rst_n & (state_q == ERROR);

`ifdef STALL_PERF_CNT_EN
  logic squash;
  assign squash = rst_n & ~freeze & branch_taken;

  stall_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write_en),
    .count (stall_cycles)
  );

  stall_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (squash),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
